apb_regfile_slave: RTL and testbench

Parametrised APB slave with a byte-strobed register bank, programmable wait states and error response, the successor to the fixed-ready display-only APB test slave. Sits behind an APB interconnect in subsystem examples and testbenches as a real, addressable memory-mapped target. It exercises the wait-state and error paths of masters and interconnects.

---
 rtl/apb_slave_pkg.sv | 24 ++
 rtl/apb_regfile_bank.sv | 48 ++++
 rtl/apb_regfile_slave.sv | 133 +++++++++++++
 tb/tb_apb_regfile_slave.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared definitions for the APB register-file slave: FSM state encoding,
// wait-counter width and address-decode helper functions.
package apb_slave_pkg;

    // Slave protocol state: waiting for a setup phase, or inside an access phase
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Wait counter is wide enough for WAIT_STATES up to 255
    localparam int WAIT_CNT_WIDTH = 8;

    // Number of byte-offset bits below the register index
    function automatic int addr_lsb(input int wstrb_width);
        return (wstrb_width > 1) ? $clog2(wstrb_width) : 0;
    endfunction

    // Bits needed to select one of num_regs registers (at least one bit)
    function automatic int index_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/apb_regfile_bank.sv
// Register storage for the APB slave: NUM_REGS words of DATA_WIDTH bits,
// one byte-strobed write port and one asynchronous read port.
// Every word clears to zero on reset.
module apb_regfile_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    we_i,
    input  logic [IDX_WIDTH-1:0]    waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [IDX_WIDTH-1:0]    raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] rows [NUM_REGS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : row_g
            logic [DATA_WIDTH-1:0] word_q;

            // Byte-lane update of this word when it is the write target
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    word_q <= '0;
                end else if (we_i && (waddr_i == IDX_WIDTH'(gi))) begin
                    for (int b = 0; b < LANES; b++) begin
                        if (wstrb_i[b]) begin
                            word_q[8*b +: 8] <= wdata_i[8*b +: 8];
                        end
                    end
                end
            end

            assign rows[gi] = word_q;
        end
    endgenerate

    // Out-of-range indices (NUM_REGS not a power of two) read as zero
    assign rdata_o = (32'(raddr_i) < NUM_REGS) ? rows[raddr_i] : '0;

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave exposing a byte-strobed register bank with a fixed number of
// wait states per access and an error response for unmapped or misaligned
// addresses. Holds the protocol FSM, wait counter, decode and optional trace.
// Optional feature: define APB_SLAVE_TRACE_EN to print every completed
// transfer during simulation; the synthesised logic is unchanged.
module apb_regfile_slave
    import apb_slave_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_REGS    = 8,
    parameter  int WAIT_STATES = 0,
    parameter  int ID          = 0,
    localparam int WSTRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_psel,
    input  logic                   s_penable,
    input  logic                   s_pwrite,
    input  logic [ADDR_WIDTH-1:0]  s_paddr,
    input  logic [DATA_WIDTH-1:0]  s_pwdata,
    input  logic [WSTRB_WIDTH-1:0] s_pstrb,
    output logic [DATA_WIDTH-1:0]  s_prdata,
    output logic                   s_pready,
    output logic                   s_pslverr
);

    localparam int LSB   = addr_lsb(WSTRB_WIDTH);
    localparam int IDX_W = index_width(NUM_REGS);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_INIT = WAIT_CNT_WIDTH'(WAIT_STATES);

    state_e                    state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                      ready;
    logic                      complete;
    logic                      misalign;
    logic                      addr_err;
    logic [ADDR_WIDTH-1:0]     index_full;
    logic [IDX_W-1:0]          bank_idx;
    logic [DATA_WIDTH-1:0]     bank_rdata;
    logic                      bank_we;

    // Address decode: word index and error classification
    assign index_full = s_paddr >> LSB;
    assign bank_idx   = index_full[IDX_W-1:0];

    generate
        if (LSB > 0) begin : align_g
            assign misalign = |s_paddr[LSB-1:0];
        end else begin : noalign_g
            assign misalign = 1'b0;
        end
    endgenerate

    assign addr_err = misalign || (index_full >= ADDR_WIDTH'(NUM_REGS));

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: count down wait states, complete or abandon the access
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_psel && !s_penable) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_INIT;
                end
            end
            ACCESS: begin
                ready = (cnt_q == '0);
                if (!s_psel) begin
                    // Master dropped the select mid-transfer: abandon silently
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!ready) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (s_penable) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bank_we   = complete && s_pwrite && !addr_err;
    assign s_pready  = ready;
    assign s_pslverr = ready && addr_err;
    assign s_prdata  = (ready && !s_pwrite && !addr_err) ? bank_rdata : '0;

    apb_regfile_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .IDX_WIDTH (IDX_W)
    ) u_bank (
        .clk    (clk),
        .rstn   (rstn),
        .we_i   (bank_we),
        .waddr_i(bank_idx),
        .wdata_i(s_pwdata),
        .wstrb_i(s_pstrb),
        .raddr_i(bank_idx),
        .rdata_o(bank_rdata)
    );

`ifdef APB_SLAVE_TRACE_EN
    // Simulation trace of each completed transfer
    always @(posedge clk) begin
        if (rstn && complete) begin
            $display("apb_slave[%0d] %s addr=%h data=%h strb=%h err=%0d",
                     ID, s_pwrite ? "W" : "R", s_paddr,
                     s_pwrite ? s_pwdata : s_prdata, s_pstrb, addr_err);
        end
    end
`endif

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Testbench for apb_regfile_slave: three instances with 0, 3 and 5 wait
// states, driven by directed and random APB transfers and checked against
// an array model of the register contents.
module tb_apb_regfile_slave;

    localparam int NDUT = 3;
    localparam int NR   = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn    [NDUT];
    logic        psel    [NDUT];
    logic        penable [NDUT];
    logic        pwrite  [NDUT];
    logic [31:0] paddr   [NDUT];
    logic [31:0] pwdata  [NDUT];
    logic [3:0]  pstrb   [NDUT];
    logic [31:0] prdata  [NDUT];
    logic        pready  [NDUT];
    logic        pslverr [NDUT];

    logic [31:0] mem_m [NDUT][NR];
    int checks   = 0;
    int failures = 0;

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
    endfunction

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : dut_g
            apb_regfile_slave #(
                .ADDR_WIDTH (32),
                .DATA_WIDTH (32),
                .NUM_REGS   (NR),
                .WAIT_STATES((gi == 0) ? 0 : ((gi == 1) ? 3 : 5)),
                .ID         (gi)
            ) u_dut (
                .clk      (clk),
                .rstn     (rstn[gi]),
                .s_psel   (psel[gi]),
                .s_penable(penable[gi]),
                .s_pwrite (pwrite[gi]),
                .s_paddr  (paddr[gi]),
                .s_pwdata (pwdata[gi]),
                .s_pstrb  (pstrb[gi]),
                .s_prdata (prdata[gi]),
                .s_pready (pready[gi]),
                .s_pslverr(pslverr[gi])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic bit exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(NR));
    endfunction

    function automatic logic [31:0] exp_read(input int d, input logic [31:0] a);
        if (exp_err(a)) return 32'h0;
        return mem_m[d][int'(a >> 2)];
    endfunction

    task automatic model_write(input int d, input logic [31:0] a,
                               input logic [31:0] data, input logic [3:0] strb);
        if (!exp_err(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem_m[d][int'(a >> 2)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic model_clear(input int d);
        for (int r = 0; r < NR; r++) mem_m[d][r] = 32'h0;
    endtask

    // ---------------- APB driver ----------------
    // One transfer; returns data/error at the ready cycle, the number of
    // not-ready access cycles, whether outputs were nonzero before ready,
    // and whether the ready wait ran out.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic err, output int waits,
                        output bit early_bad, output bit timeout);
        @(negedge clk);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = data; pstrb[d] = strb;
        @(negedge clk);
        penable[d] = 1'b1;
        #1;
        waits = 0; early_bad = 1'b0; timeout = 1'b1; rd = 32'h0; err = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (pready[d] === 1'b1) begin
                rd = prdata[d]; err = pslverr[d]; timeout = 1'b0;
                break;
            end
            if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) early_bad = 1'b1;
            waits++;
            @(negedge clk);
            #1;
        end
        if (wr) model_write(d, a, data, strb);
    endtask

    task automatic bus_idle(input int d);
        @(negedge clk);
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd; logic err; int w; bit eb, to;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got ready=%b err=%b data=%h want 0/0/0",
                         d, pready[d], pslverr[d], prdata[d]);
            end
        end
        for (int d = 0; d < NDUT; d++) rstn[d] = 1'b1;
        for (int r = 0; r < NR; r += 7) begin
            xfer(0, 1'b0, 32'(r * 4), 32'h0, 4'h0, rd, err, w, eb, to);
            checks++;
            if (rd !== 32'h0 || err !== 1'b0 || to) begin
                failures++;
                $display("FAIL reset_reg r=%0d got data=%h err=%b want 0/0", r, rd, err);
            end
        end
        bus_idle(0);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic err; int w; bit eb, to;
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, rd, err, w, eb, to);
        checks++;
        if (err !== 1'b0 || w != 0 || to) begin
            failures++;
            $display("FAIL basic_write got err=%b waits=%0d want err=0 waits=0", err, w);
        end
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, w, eb, to);
        checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0 || w != 0 || to) begin
            failures++;
            $display("FAIL basic_read got data=%h err=%b waits=%0d want DEADBEEF/0/0", rd, err, w);
        end
        bus_idle(0);
        $display("test_basic done");
    endtask

    task automatic test_partial_strobe();
        logic [31:0] rd; logic err; int w; bit eb, to;
        xfer(0, 1'b1, 32'h08, 32'h11223344, 4'hF, rd, err, w, eb, to);
        xfer(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'h5, rd, err, w, eb, to);
        xfer(0, 1'b1, 32'h08, 32'h55555555, 4'h0, rd, err, w, eb, to);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL zero_strobe_err got %b want 0", err);
        end
        xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, rd, err, w, eb, to);
        checks++;
        if (rd !== 32'h11BB33DD || rd !== exp_read(0, 32'h08) || err !== 1'b0) begin
            failures++;
            $display("FAIL partial_strobe got data=%h err=%b want 11BB33DD/0", rd, err);
        end
        bus_idle(0);
        $display("test_partial_strobe done");
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int w; bit eb, to;
        xfer(1, 1'b1, 32'h00, 32'hCAFEF00D, 4'hF, rd, err, w, eb, to);
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, rd, err, w, eb, to);
        checks++;
        if (w != 3 || eb || to) begin
            failures++;
            $display("FAIL wait_count got waits=%0d early_nonzero=%0d timeout=%0d want 3/0/0", w, eb, to);
        end
        checks++;
        if (rd !== 32'hCAFEF00D || err !== 1'b0) begin
            failures++;
            $display("FAIL wait_read got data=%h err=%b want CAFEF00D/0", rd, err);
        end
        bus_idle(1);
        $display("test_wait_states done");
    endtask

    task automatic test_error();
        logic [31:0] rd; logic err; int w; bit eb, to;
        xfer(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, rd, err, w, eb, to);
        checks++;
        if (err !== 1'b1 || w != 0 || to) begin
            failures++;
            $display("FAIL err_range got err=%b waits=%0d want 1/0", err, w);
        end
        xfer(0, 1'b1, 32'h06, 32'hFFFFFFFF, 4'hF, rd, err, w, eb, to);
        checks++;
        if (err !== 1'b1 || to) begin
            failures++;
            $display("FAIL err_misalign got err=%b want 1", err);
        end
        xfer(0, 1'b0, 32'h24, 32'h0, 4'h0, rd, err, w, eb, to);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL err_read got err=%b data=%h want 1/00000000", err, rd);
        end
        for (int r = 0; r < NR; r++) begin
            xfer(0, 1'b0, 32'(r * 4), 32'h0, 4'h0, rd, err, w, eb, to);
            checks++;
            if (rd !== mem_m[0][r] || err !== 1'b0) begin
                failures++;
                $display("FAIL err_unchanged r=%0d got %h want %h", r, rd, mem_m[0][r]);
            end
        end
        bus_idle(0);
        $display("test_error done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int w; bit eb, to;
        logic [31:0] v0, v1;
        v0 = $urandom; v1 = $urandom;
        xfer(0, 1'b1, 32'h00, v0, 4'hF, rd, err, w, eb, to);
        xfer(0, 1'b1, 32'h1C, v1, 4'hF, rd, err, w, eb, to);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, rd, err, w, eb, to);
        checks++;
        if (rd !== v0 || w != 0) begin
            failures++;
            $display("FAIL b2b_reg0 got %h waits=%0d want %h/0", rd, w, v0);
        end
        xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, rd, err, w, eb, to);
        checks++;
        if (rd !== v1 || w != 0) begin
            failures++;
            $display("FAIL b2b_reg7 got %h waits=%0d want %h/0", rd, w, v1);
        end
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, err, w, eb, to);
        checks++;
        if (rd !== exp_read(0, 32'h04)) begin
            failures++;
            $display("FAIL b2b_reg1 got %h want %h", rd, exp_read(0, 32'h04));
        end
        bus_idle(0);
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        logic [31:0] rd, a, data, want; logic err; int w; bit eb, to, wr, werr;
        logic [3:0] strb;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                wr   = 1'($urandom_range(0, 1));
                a    = 32'($urandom_range(0, 9) * 4);
                if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                want = exp_read(d, a);
                werr = exp_err(a);
                xfer(d, wr, a, data, strb, rd, err, w, eb, to);
                checks++;
                if (err !== werr || w != ws_of(d) || eb || to ||
                    (!wr && rd !== want)) begin
                    failures++;
                    $display("FAIL random dut=%0d %s addr=%h got data=%h err=%b waits=%0d want data=%h err=%b waits=%0d",
                             d, wr ? "W" : "R", a, rd, err, w, want, werr, ws_of(d));
                end
            end
            bus_idle(d);
            $display("test_random dut=%0d done", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int w; bit eb, to;
        xfer(2, 1'b1, 32'h0C, 32'h12345678, 4'hF, rd, err, w, eb, to);
        xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, rd, err, w, eb, to);
        checks++;
        if (rd !== 32'h12345678 || w != 5) begin
            failures++;
            $display("FAIL mid_preload got %h waits=%0d want 12345678/5", rd, w);
        end
        // Start a write and reset it during its second access cycle
        @(negedge clk);
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h0C; pwdata[2] = 32'h99999999; pstrb[2] = 4'hF;
        @(negedge clk);
        penable[2] = 1'b1;
        @(negedge clk);
        rstn[2] = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
        #1;
        checks++;
        if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0 || prdata[2] !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs got ready=%b err=%b data=%h want 0/0/0",
                     pready[2], pslverr[2], prdata[2]);
        end
        model_clear(2);
        @(negedge clk);
        rstn[2] = 1'b1;
        xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, rd, err, w, eb, to);
        checks++;
        if (rd !== 32'h0 || err !== 1'b0 || w != 5 || to) begin
            failures++;
            $display("FAIL mid_reset_read got data=%h err=%b waits=%0d want 0/0/5", rd, err, w);
        end
        bus_idle(2);
        $display("test_reset_mid done");
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rstn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 32'h0; pwdata[d] = 32'h0; pstrb[d] = 4'h0;
            model_clear(d);
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_partial_strobe();
        test_wait_states();
        test_error();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
